ysyx_22050039_ifu_prefetch: RTL and testbench



---
 rtl/ysyx_22050039_ifu_prefetch_if.sv | 44 ++++
 rtl/ysyx_22050039_ifu_prefetch.sv | 131 +++++++++++++
 tb/tb_ysyx_22050039_ifu_prefetch.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050039_ifu_prefetch_if.sv
// Fetch-side bundle: instruction-memory request/response, IDU delivery port and EXU redirect.
// master = fetch unit, slave = surrounding memory/pipeline.
interface ysyx_22050039_ifu_prefetch_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32,
    parameter int DEPTH    = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_resp_valid;
    logic [INST_LEN-1:0] imem_resp_data;
    logic                imem_resp_err;
    logic                inst_valid;
    logic                inst_ready;
    logic [INST_LEN-1:0] inst;
    logic [XLEN-1:0]     inst_pc;
    logic                inst_fault;
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic [CNT_W-1:0]    fifo_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fifo_count
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fifo_count
    );
endinterface

// File: rtl/ysyx_22050039_ifu_prefetch.sv
// Instruction fetch unit: single-outstanding imem request FSM feeding a DEPTH-entry
// prefetch FIFO of {inst, pc, fault}; an EXU redirect flushes the FIFO and retargets fetch.
module ysyx_22050039_ifu_prefetch #(
    parameter int          XLEN     = 64,
    parameter int          INST_LEN = 32,
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_22050039_ifu_prefetch_if.master bus
);
    localparam int STEP  = INST_LEN / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [XLEN-1:0]  STEP_X     = XLEN'(STEP);
    localparam logic [XLEN-1:0]  PC_MASK    = ~(XLEN'(STEP - 1));
    localparam logic [XLEN-1:0]  RESET_PC_X = RESET_PC[XLEN-1:0];
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t              state_q;
    logic [XLEN-1:0]     fetch_pc_q;
    logic [XLEN-1:0]     req_pc_q;

    logic [INST_LEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0]     pc_q   [DEPTH];
    logic                err_q  [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic redirect;
    logic req_fire;
    logic push;
    logic pop;
    logic head_valid;

    assign redirect   = bus.redirect_valid;
    assign head_valid = (count_q != '0);

    // Gated by rst so the request line is quiet while reset is held.
    assign bus.imem_req_valid = rst && (state_q == S_REQ) && (count_q < DEPTH_C) && !redirect;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign push = (state_q == S_WAIT) && bus.imem_resp_valid && !redirect;
    assign pop  = head_valid && bus.inst_ready && !redirect;

    assign bus.inst_valid = head_valid;
    assign bus.inst       = head_valid ? data_q[rd_ptr_q] : '0;
    assign bus.inst_pc    = head_valid ? pc_q[rd_ptr_q]   : '0;
    assign bus.inst_fault = head_valid ? err_q[rd_ptr_q]  : 1'b0;
    assign bus.fifo_count = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC_X;
            req_pc_q   <= '0;
        end else if (redirect) begin
            fetch_pc_q <= bus.redirect_pc & PC_MASK;
            // A request still in flight must be drained before fetching again.
            case (state_q)
                S_WAIT, S_DRAIN: state_q <= bus.imem_resp_valid ? S_REQ : S_DRAIN;
                default:         state_q <= S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        fetch_pc_q <= fetch_pc_q + STEP_X;
                        req_pc_q   <= fetch_pc_q;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        state_q <= bus.imem_resp_err ? S_HALT : S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_resp_valid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= bus.imem_resp_data;
            pc_q[wr_ptr_q]   <= req_pc_q;
            err_q[wr_ptr_q]  <= bus.imem_resp_err;
        end
    end

    // Request gating keeps one slot free for the single outstanding response.
    assert property (@(posedge clk) disable iff (!rst) !(push && !pop && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_ysyx_22050039_ifu_prefetch.sv
// Directed bench for the prefetching IFU: behavioural imem with programmable latency,
// scoreboard of expected FIFO entries, and a consumer that checks every popped head.
module tb_ysyx_22050039_ifu_prefetch;
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_t;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ysyx_22050039_ifu_prefetch_if #(.XLEN(64), .INST_LEN(32), .DEPTH(4)) bus ();

    ysyx_22050039_ifu_prefetch #(
        .XLEN(64), .INST_LEN(32), .DEPTH(4), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 1;
    int          epoch = 0;
    logic [63:0] err_addr = '1;
    logic        pend = 1'b0;
    exp_t        exp_q[$];
    logic [63:0] req_log[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wait_reqs(input int n, input string tag);
        int k = 0;
        while (req_log.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (req_log.size() < n) chk(tag, 64'(req_log.size()), 64'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        epoch++;
        pend = 1'b0;
        exp_q.delete();
        req_log.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        epoch++;
        exp_q.delete();
    endtask

    // Instruction memory: answers mem_lat cycles after each accepted request.
    initial begin : imem_model
        logic        fired;
        logic [63:0] faddr;
        logic [63:0] paddr;
        int          fepoch;
        int          pepoch;
        int          cnt;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.imem_resp_err   = 1'b0;
        paddr = '0; pepoch = 0; cnt = 0;
        forever begin
            @(posedge clk);
            fired  = rst && bus.imem_req_valid && bus.imem_req_ready;
            faddr  = bus.imem_req_addr;
            fepoch = epoch;
            if (fired) req_log.push_back(faddr);
            @(negedge clk);
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
            bus.imem_resp_err   = 1'b0;
            if (fired) begin
                pend = 1'b1; paddr = faddr; pepoch = fepoch; cnt = mem_lat - 1;
            end
            if (pend) begin
                if (cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = inst_of(paddr);
                    bus.imem_resp_err   = (paddr == err_addr);
                    pend = 1'b0;
                    if (pepoch == epoch) exp_q.push_back('{inst_of(paddr), paddr, paddr == err_addr});
                end else begin
                    cnt--;
                end
            end
        end
    end

    // IDU side: every accepted head must match the oldest scoreboard entry.
    initial begin : consumer
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && !bus.redirect_valid && bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_entry_valid", 64'(bus.inst_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_inst",  64'(bus.inst),       64'(e.inst));
                    chk("head_pc",    bus.inst_pc,         e.pc);
                    chk("head_fault", 64'(bus.inst_fault), 64'(e.fault));
                end
            end
        end
    end

    initial begin : stimulus
        int k;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset values and first-request latency, FIFO fill with IDU stalled.
        repeat (2) @(negedge clk);
        chk("rst_req_valid",  64'(bus.imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(bus.inst_valid),     64'd0);
        chk("rst_count",      64'(bus.fifo_count),     64'd0);
        chk("rst_inst",       64'(bus.inst),           64'd0);
        chk("rst_inst_pc",    bus.inst_pc,             64'd0);
        chk("rst_inst_fault", 64'(bus.inst_fault),     64'd0);
        rst = 1'b1;
        #1;
        chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("first_req_addr",  bus.imem_req_addr,       RST_PC);
        @(negedge clk);
        chk("lat_count_n1", 64'(bus.fifo_count), 64'd0);
        @(negedge clk);
        chk("lat_inst_valid", 64'(bus.inst_valid), 64'd1);
        chk("lat_inst_pc",    bus.inst_pc,         RST_PC);
        wait_reqs(4, "fill_timeout");
        repeat (4) @(negedge clk);
        chk("full_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("full_count",     64'(bus.fifo_count),     64'd4);
        chk("full_nreq",      64'(req_log.size()),     64'd4);
        for (int i = 0; i < 4; i++) chk("fill_addr", req_log[i], RST_PC + 64'(4 * i));
        bus.inst_ready = 1'b1;
        wait_reqs(5, "resume_timeout");
        chk("resume_addr", req_log[4], RST_PC + 64'h10);
        repeat (6) @(negedge clk);

        // Memory back-pressure: request held stable, PC advances once per fire.
        bus.imem_req_ready = 1'b0;
        do_reset();
        repeat (3) begin
            @(negedge clk);
            chk("stall_req_valid", 64'(bus.imem_req_valid), 64'd1);
            chk("stall_req_addr",  bus.imem_req_addr,       RST_PC);
        end
        bus.imem_req_ready = 1'b1;
        wait_reqs(2, "stall_timeout");
        chk("stall_fire_addr", req_log[0], RST_PC);
        chk("stall_next_addr", req_log[1], RST_PC + 64'h4);
        repeat (6) @(negedge clk);

        // Redirect during WAIT with two entries queued; response drained.
        bus.inst_ready = 1'b0;
        do_reset();
        k = 0;
        while (bus.fifo_count != 2 && k < 100) begin @(negedge clk); k++; end
        if (bus.fifo_count != 2) chk("fill2_timeout", 64'(bus.fifo_count), 64'd2);
        mem_lat = 3;
        wait_reqs(3, "slow_req_timeout");
        redirect_to(64'h0000_0000_8000_1002);
        #1;
        chk("redir_no_fire", 64'(bus.imem_req_valid), 64'd0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        chk("redir_flush_count", 64'(bus.fifo_count), 64'd0);
        chk("drain_req_valid",   64'(bus.imem_req_valid), 64'd0);
        mem_lat = 1;
        wait_reqs(4, "drain_timeout");
        chk("redir_addr", req_log[3], 64'h0000_0000_8000_1000);

        // Redirect coinciding with a response and a pop.
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(bus.imem_resp_valid && bus.inst_valid) && k < 100);
        if (!(bus.imem_resp_valid && bus.inst_valid)) chk("collide_timeout", 64'(bus.imem_resp_valid), 64'd1);
        bus.inst_ready = 1'b1;
        redirect_to(64'h0000_0000_8000_2000);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        #1;
        chk("collide_count",      64'(bus.fifo_count),     64'd0);
        chk("collide_inst_valid", 64'(bus.inst_valid),     64'd0);
        chk("collide_req_valid",  64'(bus.imem_req_valid), 64'd1);
        chk("collide_req_addr",   bus.imem_req_addr,       64'h0000_0000_8000_2000);
        bus.inst_ready = 1'b1;
        repeat (12) @(negedge clk);

        // Access fault halts fetch; redirect resumes.
        err_addr = 64'h0000_0000_8000_0008;
        do_reset();
        wait_reqs(3, "fault_timeout");
        repeat (10) @(negedge clk);
        chk("halt_nreq",      64'(req_log.size()),     64'd3);
        chk("halt_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("halt_count",     64'(bus.fifo_count),     64'd0);
        err_addr = '1;
        redirect_to(64'h0000_0000_8000_0100);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        wait_reqs(4, "unhalt_timeout");
        chk("unhalt_addr", req_log[3], 64'h0000_0000_8000_0100);
        repeat (6) @(negedge clk);

        // Reset asserted mid-WAIT; stale response afterwards must be ignored.
        bus.inst_ready = 1'b0;
        do_reset();
        mem_lat = 3;
        wait_reqs(1, "stale_req_timeout");
        bus.imem_req_ready = 1'b0;
        rst = 1'b0;
        epoch++;
        exp_q.delete();
        req_log.delete();
        #1;
        chk("async_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("async_rst_count",     64'(bus.fifo_count),     64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("stale_count",      64'(bus.fifo_count),     64'd0);
        chk("stale_inst_valid", 64'(bus.inst_valid),     64'd0);
        chk("stale_req_valid",  64'(bus.imem_req_valid), 64'd1);
        chk("stale_req_addr",   bus.imem_req_addr,       RST_PC);
        mem_lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        wait_reqs(1, "post_stale_timeout");
        chk("post_stale_addr", req_log[0], RST_PC);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
